// File: rtl/gate_tb_pkg.sv
// Shared definitions for the gate sweep controller.
// Holds the sweep FSM state encoding and the reference truth tables of
// the common 3-input gates. These tables are used as EXPECT values when
// the controller is instantiated beside a gate block.
package gate_tb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } sweep_state_e;

    // Bit i of each table is the gate output for input vector i.
    localparam logic [7:0] TT_AND3  = 8'h80;
    localparam logic [7:0] TT_OR3   = 8'hFE;
    localparam logic [7:0] TT_XOR3  = 8'h96;
    localparam logic [7:0] TT_NAND3 = 8'h7F;

endpackage

// File: rtl/sweep_result_tracker.sv
// Result bookkeeping for one gate sweep.
// It counts mismatching samples and captures the first failing vector.
// It also registers the pass verdict when the last vector is sampled.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   i_clear             start of a new sweep: zero all results
//   i_sample_valid      a sample is being taken this cycle
//   i_mismatch          the sampled gate output differs from the table
//   i_vec               vector being sampled
//   o_err_count         mismatches so far in this sweep
//   o_first_fail_vec    first mismatching vector
//   o_first_fail_valid  o_first_fail_vec holds a captured value
//   o_pass              sweep finished with no mismatch
module sweep_result_tracker #(
    parameter int N_IN = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_clear,
    input  logic            i_sample_valid,
    input  logic            i_mismatch,
    input  logic [N_IN-1:0] i_vec,
    output logic [N_IN:0]   o_err_count,
    output logic [N_IN-1:0] o_first_fail_vec,
    output logic            o_first_fail_valid,
    output logic            o_pass
);

    localparam logic [N_IN-1:0] VEC_LAST = {N_IN{1'b1}};

    logic [N_IN:0]   r_err_count;
    logic [N_IN-1:0] r_first_fail_vec;
    logic            r_first_fail_valid;
    logic            r_pass;
    logic            w_hit;
    logic            w_last;
    logic [N_IN:0]   w_err_next;

    // Mismatch count including the sample taken this cycle.
    always_comb begin
        w_hit      = i_sample_valid & i_mismatch;
        w_last     = (i_vec == VEC_LAST);
        w_err_next = r_err_count + {{N_IN{1'b0}}, w_hit};
    end

    // Result registers: cleared per sweep, updated on each sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_count        <= {(N_IN+1){1'b0}};
            r_first_fail_vec   <= {N_IN{1'b0}};
            r_first_fail_valid <= 1'b0;
            r_pass             <= 1'b0;
        end else if (i_clear) begin
            r_err_count        <= {(N_IN+1){1'b0}};
            r_first_fail_vec   <= {N_IN{1'b0}};
            r_first_fail_valid <= 1'b0;
            r_pass             <= 1'b0;
        end else if (i_sample_valid) begin
            r_err_count <= w_err_next;
            if (w_hit && !r_first_fail_valid) begin
                r_first_fail_vec   <= i_vec;
                r_first_fail_valid <= 1'b1;
            end
            // The verdict is only meaningful once the final vector is in.
            if (w_last) begin
                r_pass <= (w_err_next == {(N_IN+1){1'b0}});
            end
        end
    end

    assign o_err_count        = r_err_count;
    assign o_first_fail_vec   = r_first_fail_vec;
    assign o_first_fail_valid = r_first_fail_valid;
    assign o_pass             = r_pass;

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Self-checking sweep controller for an N_IN-input combinational gate.
// It walks gate_in through every input vector in ascending order and
// holds each vector for HOLD cycles. It then samples gate_out for one
// cycle and compares it against the EXPECT truth table.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             begin a sweep (accepted in IDLE or DONE)
//   abort             return to IDLE at once; wins over start
//   gate_in           vector driven to the gate under test
//   gate_out          output of the gate under test
//   busy              sweep in progress
//   done              sweep complete (sticky until start/abort/rst)
//   pass              no mismatches; valid with done
//   err_count         mismatching vectors in current or last sweep
//   first_fail_vec    first mismatching vector
//   first_fail_valid  first_fail_vec holds a captured value
//   sample_valid      one-cycle pulse while a vector is sampled
//   sample_vec        vector being sampled
module gate_sweep_ctrl
    import gate_tb_pkg::*;
#(
    parameter int                   N_IN   = 3,
    parameter int                   HOLD   = 2,
    parameter logic [(2**N_IN)-1:0] EXPECT = TT_AND3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    output logic [N_IN-1:0] gate_in,
    input  logic            gate_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] first_fail_vec,
    output logic            first_fail_valid,
    output logic            sample_valid,
    output logic [N_IN-1:0] sample_vec
);

    localparam int              HOLD_W    = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD - 1);
    localparam logic [N_IN-1:0] VEC_LAST  = {N_IN{1'b1}};

    sweep_state_e      r_state;
    sweep_state_e      w_state_next;
    logic [N_IN-1:0]   r_vec;
    logic [N_IN-1:0]   w_vec_next;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [HOLD_W-1:0] w_hold_next;
    logic [N_IN-1:0]   r_gate_in;
    logic [N_IN-1:0]   w_gate_in_next;
    logic              r_busy;
    logic              w_busy_next;
    logic              r_done;
    logic              w_done_next;
    logic              w_clear;
    logic              w_sample_take;
    logic              w_mismatch;

    // Next-state, counter and registered-output decode.
    always_comb begin
        w_state_next   = r_state;
        w_vec_next     = r_vec;
        w_hold_next    = r_hold_cnt;
        w_clear        = 1'b0;
        w_gate_in_next = {N_IN{1'b0}};
        w_busy_next    = 1'b0;
        w_done_next    = 1'b0;

        if (abort) begin
            w_state_next = ST_IDLE;
            w_hold_next  = {HOLD_W{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        w_state_next = ST_DRIVE;
                        w_vec_next   = {N_IN{1'b0}};
                        w_hold_next  = {HOLD_W{1'b0}};
                        w_clear      = 1'b1;
                    end else begin
                        w_state_next = r_state;
                    end
                end
                ST_DRIVE: begin
                    if (r_hold_cnt == HOLD_LAST) begin
                        w_state_next = ST_SAMPLE;
                        w_hold_next  = {HOLD_W{1'b0}};
                    end else begin
                        w_hold_next  = r_hold_cnt + {{(HOLD_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_SAMPLE: begin
                    if (r_vec == VEC_LAST) begin
                        w_state_next = ST_DONE;
                    end else begin
                        w_state_next = ST_DRIVE;
                        w_vec_next   = r_vec + {{(N_IN-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end

        // Outputs are registered from the next state so they line up with it.
        case (w_state_next)
            ST_DRIVE, ST_SAMPLE: begin
                w_gate_in_next = w_vec_next;
                w_busy_next    = 1'b1;
            end
            ST_DONE: begin
                w_done_next = 1'b1;
            end
            default: begin
                w_gate_in_next = {N_IN{1'b0}};
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_vec      <= {N_IN{1'b0}};
            r_hold_cnt <= {HOLD_W{1'b0}};
            r_gate_in  <= {N_IN{1'b0}};
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_vec      <= w_vec_next;
            r_hold_cnt <= w_hold_next;
            r_gate_in  <= w_gate_in_next;
            r_busy     <= w_busy_next;
            r_done     <= w_done_next;
        end
    end

    // An aborted sample is discarded so the retained results stay consistent.
    assign w_sample_take = (r_state == ST_SAMPLE) && !abort;
    assign w_mismatch    = (gate_out != EXPECT[r_vec]);

    sweep_result_tracker #(
        .N_IN (N_IN)
    ) u_tracker (
        .clk                (clk),
        .rst                (rst),
        .i_clear            (w_clear),
        .i_sample_valid     (w_sample_take),
        .i_mismatch         (w_mismatch),
        .i_vec              (r_vec),
        .o_err_count        (err_count),
        .o_first_fail_vec   (first_fail_vec),
        .o_first_fail_valid (first_fail_valid),
        .o_pass             (pass)
    );

    assign gate_in      = r_gate_in;
    assign busy         = r_busy;
    assign done         = r_done;
    assign sample_valid = (r_state == ST_SAMPLE);
    assign sample_vec   = r_vec;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Randomized bench for gate_sweep_ctrl against a truth-table reference model.
module tb_gate_sweep_ctrl;

    localparam int HOLD  = 2;
    localparam int NVEC  = 8;
    localparam int SWEEP = NVEC * (HOLD + 1);
    localparam logic [7:0] EXP_A = 8'h80;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic [2:0] gate_in;
    logic       gate_out;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] err_count;
    logic [2:0] first_fail_vec;
    logic       first_fail_valid;
    logic       sample_valid;
    logic [2:0] sample_vec;

    logic       start_or;
    logic [2:0] gate_in_or;
    logic       gate_out_or;
    logic       busy_or;
    logic       done_or;
    logic       pass_or;
    logic [3:0] err_count_or;
    logic [2:0] ffvec_or;
    logic       ffv_or;
    logic       sv_or;
    logic [2:0] svec_or;

    logic [7:0] tt_gate;
    logic [7:0] tt_gate_or;

    int n_checks;
    int n_errors;

    assign gate_out    = tt_gate[gate_in];
    assign gate_out_or = tt_gate_or[gate_in_or];

    gate_sweep_ctrl #(.N_IN(3), .HOLD(HOLD), .EXPECT(EXP_A)) u_dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .gate_in(gate_in), .gate_out(gate_out), .busy(busy), .done(done),
        .pass(pass), .err_count(err_count), .first_fail_vec(first_fail_vec),
        .first_fail_valid(first_fail_valid), .sample_valid(sample_valid),
        .sample_vec(sample_vec)
    );

    gate_sweep_ctrl #(.N_IN(3), .HOLD(HOLD), .EXPECT(gate_tb_pkg::TT_OR3)) u_dut_or (
        .clk(clk), .rst(rst), .start(start_or), .abort(1'b0),
        .gate_in(gate_in_or), .gate_out(gate_out_or), .busy(busy_or), .done(done_or),
        .pass(pass_or), .err_count(err_count_or), .first_fail_vec(ffvec_or),
        .first_fail_valid(ffv_or), .sample_valid(sv_or), .sample_vec(svec_or)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Full sweep on the AND instance; restart_at re-pulses start mid-sweep.
    task automatic run_sweep(input logic [7:0] tt, input int restart_at);
        logic [7:0] mm;
        int exp_err;
        int exp_first;
        int nxt;
        bit seen_done;
        mm = tt ^ EXP_A;
        exp_err = 0;
        exp_first = -1;
        for (int i = 0; i < NVEC; i++) begin
            if (mm[i]) begin
                exp_err++;
                if (exp_first < 0) exp_first = i;
            end
        end
        tt_gate = tt;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        check_value("start_busy", busy, 1);
        check_value("start_done", done, 0);
        check_value("start_err_clear", err_count, 0);
        check_value("start_ffv_clear", first_fail_valid, 0);
        check_value("start_gate_in", gate_in, 0);
        nxt = 0;
        seen_done = 1'b0;
        for (int c = 1; c <= SWEEP + 20 && !seen_done; c++) begin
            @(posedge clk); #1;
            start = (c == restart_at);
            if (c < SWEEP) check_value("gate_in_seq", gate_in, c / (HOLD + 1));
            if (sample_valid) begin
                check_value("sample_vec", sample_vec, nxt);
                check_value("sample_slot", c, nxt * (HOLD + 1) + HOLD);
                nxt++;
            end
            if (done) begin
                seen_done = 1'b1;
                check_value("latency", c, SWEEP);
                check_value("done_gate_in", gate_in, 0);
                check_value("done_busy", busy, 0);
            end
        end
        start = 1'b0;
        if (!seen_done) check_value("done_timeout", 0, 1);
        check_value("n_samples", nxt, NVEC);
        check_value("err_count", err_count, exp_err);
        check_value("pass", pass, (exp_err == 0));
        check_value("first_fail_valid", first_fail_valid, (exp_err != 0));
        if (exp_err != 0) check_value("first_fail_vec", first_fail_vec, exp_first);
    endtask

    initial begin
        logic [7:0] or_tt;
        bit hit;
        bit seen;
        clk = 1'b0;
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        start_or = 1'b0;
        tt_gate = EXP_A;
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < NVEC; i++) or_tt[i] = (i != 0);
        tt_gate_or = or_tt;

        #12;
        check_value("rst_busy", busy, 0);
        check_value("rst_done", done, 0);
        check_value("rst_gate_in", gate_in, 0);
        check_value("rst_err", err_count, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check_value("idle_pass", pass, 0);
        check_value("idle_ffv", first_fail_valid, 0);
        check_value("idle_sv", sample_valid, 0);

        run_sweep(EXP_A, -1);    // correct AND gate
        run_sweep(8'h00, -1);    // stuck-at-0
        run_sweep(8'hFF, -1);    // stuck-at-1
        run_sweep(EXP_A, 5);     // start ignored while busy
        for (int r = 0; r < 6; r++) begin
            run_sweep(8'($urandom), (r % 2 == 0) ? int'($urandom_range(1, 20)) : -1);
        end

        // Correct OR gate against the OR table.
        @(posedge clk); #1 start_or = 1'b1;
        @(posedge clk); #1 start_or = 1'b0;
        seen = 1'b0;
        for (int c = 1; c <= SWEEP + 20 && !seen; c++) begin
            @(posedge clk); #1;
            if (done_or) begin
                seen = 1'b1;
                check_value("or_latency", c, SWEEP);
            end
        end
        if (!seen) check_value("or_done_timeout", 0, 1);
        check_value("or_pass", pass_or, 1);
        check_value("or_err", err_count_or, 0);

        // abort together with start during SAMPLE of vector 4.
        tt_gate = 8'($urandom);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 40 && !hit; c++) begin
            @(posedge clk); #1;
            if (sample_valid && sample_vec == 3'd4) hit = 1'b1;
        end
        if (!hit) check_value("abort_wait_timeout", 0, 1);
        abort = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        start = 1'b0;
        check_value("abort_busy", busy, 0);
        check_value("abort_done", done, 0);
        check_value("abort_gate_in", gate_in, 0);
        check_value("abort_sv", sample_valid, 0);
        @(posedge clk); #1;
        check_value("abort_stay_idle", busy, 0);

        // Asynchronous reset during DRIVE of vector 5.
        tt_gate = 8'hFF;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 40 && !hit; c++) begin
            @(posedge clk); #1;
            if (busy && gate_in == 3'd5 && !sample_valid) hit = 1'b1;
        end
        if (!hit) check_value("rst_wait_timeout", 0, 1);
        check_value("pre_rst_err", err_count, 5);
        #2 rst = 1'b1;
        #1;
        check_value("arst_busy", busy, 0);
        check_value("arst_gate_in", gate_in, 0);
        check_value("arst_err", err_count, 0);
        check_value("arst_ffv", first_fail_valid, 0);
        check_value("arst_ffvec", first_fail_vec, 0);
        #2 rst = 1'b0;
        run_sweep(EXP_A, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/gate_sweep_ctrl.md
Name: gate_sweep_ctrl

Overview:
- Sequencer that drives an N-input combinational gate under test through all 2^N input combinations.
- Holds each vector for a settle window, samples the gate output and compares it to an expected truth table.
- Reports pass/fail, mismatch count and first failing vector.
- Sits beside the basic-gate blocks, replacing hand-written stimulus sequences with a reusable self-checking controller.

Parameters:
- N_IN, 3, number of gate inputs; legal range 1..6.
- HOLD, 2, cycles each vector is driven before sampling; must be >= 1.
- EXPECT, 8'h80, truth table, width 2^N_IN; bit i is the expected output for input vector i. The default is a 3-input AND.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  begin a sweep; honoured only in IDLE or DONE.
- abort  input  1  terminate the sweep; return to IDLE without asserting done.
- gate_in  output  N_IN  vector driven to the gate under test.
- gate_out  input  1  output of the gate under test.
- busy  output  1  high in DRIVE or SAMPLE.
- done  output  1  high in DONE; sticky until start, abort or rst.
- pass  output  1  valid when done; 1 iff err_count == 0.
- err_count  output  N_IN+1  number of mismatching vectors in the current or last sweep.
- first_fail_vec  output  N_IN  first vector that mismatched.
- first_fail_valid  output  1  first_fail_vec holds a captured value.
- sample_valid  output  1  one-cycle pulse in SAMPLE.
- sample_vec  output  N_IN  vector being sampled; qualified by sample_valid.

Behaviour:
- Reset values: state IDLE; all outputs 0; internal vec, hold_cnt and err_count 0.
- States: IDLE, DRIVE, SAMPLE, DONE. All outputs are registered, except sample_valid and sample_vec, which decode directly from state and vec.
- IDLE:
  - gate_in = 0.
  - start=1 -> DRIVE, with vec=0, hold_cnt=0, err_count=0, first_fail_valid=0.
- DRIVE:
  - gate_in = vec.
  - hold_cnt increments each cycle.
  - When hold_cnt == HOLD-1 -> SAMPLE, and hold_cnt clears.
  - DRIVE therefore occupies exactly HOLD cycles per vector.
- SAMPLE (one cycle):
  - gate_in = vec; sample_valid=1; sample_vec=vec.
  - If gate_out != EXPECT[vec]: err_count increments. If first_fail_valid==0, also capture first_fail_vec=vec and set first_fail_valid=1.
  - If vec == 2^N_IN-1 -> DONE; otherwise vec increments and the block returns to DRIVE.
- DONE:
  - done=1 and pass=(err_count==0); gate_in=0.
  - err_count and first_fail fields are held.
  - start=1 -> DRIVE with the same clearing as from IDLE (back-to-back sweeps allowed).
- Latency: if start is sampled at edge k, done is first high after edge k + 2^N_IN*(HOLD+1).
- start while busy is ignored, with no effect on state or counters.
- abort has priority over start and over all transitions:
  - Any state -> IDLE next edge.
  - done cleared; gate_in driven 0.
  - err_count and first_fail fields retain their values but are not qualified by done.
- start and abort in the same cycle: abort wins.
- rst mid-sweep: immediate asynchronous return to all reset values; no partial results are preserved.
- Widths:
  - err_count saturation is not required; max 2^N_IN fits in N_IN+1 bits.
  - vec comparison against all-ones is done on N_IN bits, so no wrap past the last vector.
- EXPECT indexing uses vec as an unsigned index; bit 0 corresponds to gate_in=0.

Decomposition:
- Shared package gate_tb_pkg holds:
  - the state enum (IDLE=0, DRIVE=1, SAMPLE=2, DONE=3);
  - localparam truth-table constants TT_AND3=8'h80, TT_OR3=8'hFE, TT_XOR3=8'h96, TT_NAND3=8'h7F.
- One sub-module, sweep_result_tracker: err_count, first_fail capture and pass logic. Inputs are sample_valid, mismatch, vec and clear.
- The FSM, vec counter and hold counter stay in gate_sweep_ctrl.

Test Plan:
- Defaults, correct 3-input AND model, start pulse -> done after 24 cycles, pass=1, err_count=0, first_fail_valid=0; sample_vec pulses 0..7 in order, every 3 cycles.
- Gate stuck-at-0 -> done, pass=0, err_count=1, first_fail_vec=7, first_fail_valid=1.
- Gate stuck-at-1 -> err_count=7, first_fail_vec=0; then EXPECT=TT_OR3 with a correct OR model -> pass=1.
- start re-pulsed at sweep cycle 5 -> ignored; done still at cycle 24; vec sequence unbroken. Then start in DONE -> counters clear and a new sweep begins next edge.
- abort asserted in SAMPLE of vec=4, with start=1 in the same cycle -> IDLE next edge, gate_in=0, done=0, busy=0.
- rst pulse during DRIVE of vec=5 -> outputs 0 immediately, without waiting for clk; after release, start -> full sweep from vec 0 with pass=1.
